// File: rtl/cbd_sampler_ctrl_if.sv
// rtl/cbd_sampler_ctrl_if.sv - PRF, CBD sampler and polynomial RAM signal bundle
// master = sequencer side, slave = PRF/sampler/RAM side.
interface cbd_sampler_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              o_prf_req;
  logic [7:0]        o_prf_nonce;
  logic [63:0]       i_prf_data;
  logic              i_prf_valid;
  logic              o_prf_ready;
  logic [1:0]        o_cbd_eta;
  logic [63:0]       o_cbd_ibytes;
  logic              o_cbd_ibytes_valid;
  logic              i_cbd_ibytes_ready;
  logic [47:0]       i_cbd_coeffs;
  logic              i_cbd_coeffs_valid;
  logic              i_cbd_done;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [191:0]      o_mem_wdata;

  modport master (
    output o_prf_req, o_prf_nonce, o_prf_ready, o_cbd_eta, o_cbd_ibytes,
           o_cbd_ibytes_valid, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_prf_data, i_prf_valid, i_cbd_ibytes_ready, i_cbd_coeffs,
           i_cbd_coeffs_valid, i_cbd_done
  );

  modport slave (
    input  o_prf_req, o_prf_nonce, o_prf_ready, o_cbd_eta, o_cbd_ibytes,
           o_cbd_ibytes_valid, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_prf_data, i_prf_valid, i_cbd_ibytes_ready, i_cbd_coeffs,
           i_cbd_coeffs_valid, i_cbd_done
  );
endinterface

// File: rtl/cbd_sampler_ctrl.sv
// rtl/cbd_sampler_ctrl.sv - sequences the CBD sampler over 1..4 noise polynomials
// Issues one PRF request per polynomial and writes mod-q coefficient words to RAM.
module cbd_sampler_ctrl #(
  parameter int Q      = 3329,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [1:0]        i_eta,
  input  logic [2:0]        i_num_poly,
  input  logic [7:0]        i_nonce_base,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  cbd_sampler_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, FEED, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        eta_q, eta_d;
  logic [2:0]        num_q, num_d;
  logic [7:0]        nonce_q, nonce_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        poly_q, poly_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [191:0]      wdata_q, wdata_d;

  logic [191:0]      conv;
  logic              conv_bad;
  logic              accept;
  logic [4:0]        cnt_after;

  // Negative v maps to Q+v; for a 3-bit pattern that is (Q-8) + raw bits.
  always_comb begin
    conv     = '0;
    conv_bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus.i_cbd_coeffs[47-3*i]) begin
        conv[191-12*i -: 12] = 12'(Q - 8) + {9'd0, bus.i_cbd_coeffs[47-3*i -: 3]};
        if (bus.i_cbd_coeffs[47-3*i -: 3] == 3'b100) conv_bad = 1'b1;
      end else begin
        conv[191-12*i -: 12] = {9'd0, bus.i_cbd_coeffs[47-3*i -: 3]};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    eta_d     = eta_q;
    num_d     = num_q;
    nonce_d   = nonce_q;
    base_d    = base_q;
    poly_d    = poly_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_after = cnt_q;
    bus.o_prf_req          = 1'b0;
    bus.o_prf_ready        = 1'b0;
    bus.o_cbd_ibytes_valid = 1'b0;
    accept = i_start && (state_q == IDLE || state_q == DONE);

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          eta_d   = i_eta;
          num_d   = i_num_poly;
          nonce_d = i_nonce_base;
          base_d  = i_base_addr;
          poly_d  = 3'd0;
          err_d   = 1'b0;
          if (i_eta != 2'd2 && i_eta != 2'd3) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (i_num_poly == 3'd0) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      REQ: begin
        bus.o_prf_req = 1'b1;
        cnt_d         = 5'd0;
        state_d       = FEED;
      end
      FEED: begin
        bus.o_cbd_ibytes_valid = bus.i_prf_valid;
        bus.o_prf_ready        = bus.i_cbd_ibytes_ready;
        if (bus.i_cbd_coeffs_valid) begin
          if (cnt_q == 5'd16) begin
            err_d = 1'b1;
          end else begin
            we_d      = 1'b1;
            addr_d    = base_q + ADDR_W'({poly_q, 4'b0000}) + ADDR_W'(cnt_q);
            wdata_d   = conv;
            cnt_after = cnt_q + 5'd1;
            if (conv_bad) err_d = 1'b1;
          end
        end
        cnt_d = cnt_after;
        // A coincident final write is counted before the completeness check.
        if (bus.i_cbd_done) begin
          if (cnt_after != 5'd16) err_d = 1'b1;
          if (poly_q == num_q - 3'd1) begin
            state_d = DONE;
          end else begin
            poly_d  = poly_q + 3'd1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      eta_q   <= '0;
      num_q   <= '0;
      nonce_q <= '0;
      base_q  <= '0;
      poly_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      eta_q   <= eta_d;
      num_q   <= num_d;
      nonce_q <= nonce_d;
      base_q  <= base_d;
      poly_q  <= poly_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.o_prf_nonce  = (state_q == REQ) ? nonce_q + {5'd0, poly_q} : 8'd0;
  assign bus.o_cbd_eta    = eta_q;
  assign bus.o_cbd_ibytes = bus.i_prf_data;
  assign bus.o_mem_we     = we_q;
  assign bus.o_mem_addr   = addr_q;
  assign bus.o_mem_wdata  = wdata_q;
  assign o_busy           = (state_q == REQ) || (state_q == FEED);
  assign o_done           = (state_q == DONE);
  assign o_err            = err_q;

endmodule

// File: tb/tb_cbd_sampler_ctrl.sv
// tb/tb_cbd_sampler_ctrl.sv - directed self-checking bench for cbd_sampler_ctrl
// The bench plays PRF, sampler and RAM; CBD and mod-q values come from integer models.
module tb_cbd_sampler_ctrl;
  localparam int ADDR_W = 8;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_start = 1'b0;
  logic [1:0] i_eta = '0;
  logic [2:0] i_num_poly = '0;
  logic [7:0] i_nonce_base = '0;
  logic [7:0] i_base_addr = '0;
  logic       o_busy, o_done, o_err;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]   got_addr[$];
  logic [191:0] got_data[$];
  logic [7:0]   got_nonce[$];
  logic [7:0]   exp_addr[$];
  logic [191:0] exp_data[$];
  int           n_done = 0;

  cbd_sampler_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  cbd_sampler_ctrl #(.Q(3329), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_eta(i_eta),
    .i_num_poly(i_num_poly), .i_nonce_base(i_nonce_base), .i_base_addr(i_base_addr),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (bus.o_mem_we === 1'b1) begin
      got_addr.push_back(bus.o_mem_addr);
      got_data.push_back(bus.o_mem_wdata);
    end
    if (bus.o_prf_req === 1'b1) got_nonce.push_back(bus.o_prf_nonce);
    if (o_done === 1'b1) n_done++;
  end

  function automatic int cbd2(input logic [63:0] w, input int i);
    int a, b;
    a = int'(w[4*i]) + int'(w[4*i+1]);
    b = int'(w[4*i+2]) + int'(w[4*i+3]);
    return a - b;
  endfunction

  function automatic logic [11:0] modq(input int c);
    return (c < 0) ? 12'(3329 + c) : 12'(c);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_logs();
    got_addr.delete(); got_data.delete(); got_nonce.delete();
    exp_addr.delete(); exp_data.delete();
    n_done = 0;
  endtask

  task automatic start_run(input logic [1:0] eta, input logic [2:0] num,
                           input logic [7:0] nb, input logic [7:0] ba);
    i_eta = eta; i_num_poly = num; i_nonce_base = nb; i_base_addr = ba;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_feed(output bit ok);
    int k = 0;
    while (bus.o_prf_req !== 1'b1 && k < 20) begin tick(); k++; end
    ok = (bus.o_prf_req === 1'b1);
    tick();
  endtask

  task automatic wait_done(output bit ok);
    int k = 0;
    while (o_done !== 1'b1 && k < 40) begin tick(); k++; end
    ok = (o_done === 1'b1);
  endtask

  // One polynomial: 16 back-to-back coefficient groups, then the sampler's done.
  task automatic feed_poly(input int eta, input logic [7:0] addr0,
                           input bit use_fixed, input logic [63:0] fixed);
    for (int g = 0; g < 16; g++) begin
      logic [63:0]  w;
      logic [47:0]  cw;
      logic [191:0] ew;
      int           c;
      w = use_fixed ? fixed : {$urandom, $urandom};
      for (int i = 0; i < 16; i++) begin
        if (eta == 2) c = cbd2(w, i);
        else          c = int'($urandom_range(6)) - 3;
        cw[47-3*i -: 3]   = 3'(c);
        ew[191-12*i -: 12] = modq(c);
      end
      bus.i_prf_data = w; bus.i_prf_valid = 1'b1;
      bus.i_cbd_coeffs = cw; bus.i_cbd_coeffs_valid = 1'b1;
      exp_addr.push_back(addr0 + 8'(g));
      exp_data.push_back(ew);
      tick();
    end
    bus.i_cbd_coeffs_valid = 1'b0; bus.i_prf_valid = 1'b0;
    bus.i_cbd_done = 1'b1;
    tick();
    bus.i_cbd_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_prf_valid = 1'b1; bus.i_cbd_ibytes_ready = 1'b1; bus.i_prf_data = 64'h0;
    i_rstn = 1'b0;
    tick(); tick();
    n_total++; if ({o_busy, o_done, o_err} !== 3'b000) $display("FAIL reset_status got=%b exp=000", {o_busy, o_done, o_err}); else n_pass++;
    n_total++; if ({bus.o_prf_req, bus.o_prf_ready, bus.o_cbd_ibytes_valid, bus.o_mem_we} !== 4'b0000)
      $display("FAIL reset_strobes got=%b exp=0000", {bus.o_prf_req, bus.o_prf_ready, bus.o_cbd_ibytes_valid, bus.o_mem_we}); else n_pass++;
    n_total++; if ({bus.o_prf_nonce, bus.o_cbd_eta, bus.o_mem_addr} !== 18'd0)
      $display("FAIL reset_fields got=%h exp=0", {bus.o_prf_nonce, bus.o_cbd_eta, bus.o_mem_addr}); else n_pass++;
    n_total++; if (bus.o_mem_wdata !== 192'd0) $display("FAIL reset_wdata got=%h exp=0", bus.o_mem_wdata); else n_pass++;
    bus.i_prf_valid = 1'b0;
    i_rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    start_run(2'd2, 3'd1, 8'h05, 8'h10);
    n_total++; if (o_busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", o_busy); else n_pass++;
    n_total++; if (bus.o_prf_nonce !== 8'h05) $display("FAIL single_nonce got=%h exp=05", bus.o_prf_nonce); else n_pass++;
    wait_feed(ok);
    n_total++; if (!ok) $display("FAIL single_req got=0 exp=1"); else n_pass++;
    n_total++; if (bus.o_cbd_eta !== 2'd2) $display("FAIL single_eta got=%0d exp=2", bus.o_cbd_eta); else n_pass++;
    feed_poly(2, 8'h10, 1'b0, 64'h0);
    wait_done(ok);
    n_total++; if (!ok || o_busy !== 1'b0) $display("FAIL single_done got=%b/%b exp=1/0", ok, o_busy); else n_pass++;
    tick();
    n_total++; if (o_done !== 1'b0 || n_done != 1) $display("FAIL single_done_pulse got=%b/%0d exp=0/1", o_done, n_done); else n_pass++;
    n_total++; if (o_err !== 1'b0) $display("FAIL single_err got=%b exp=0", o_err); else n_pass++;
    n_total++; if (got_nonce.size() != 1 || got_addr.size() != 16) $display("FAIL single_counts got=%0d/%0d exp=1/16", got_nonce.size(), got_addr.size()); else n_pass++;
    for (int k = 0; k < 16 && k < got_addr.size(); k++) begin
      n_total++; if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k])
        $display("FAIL single_wr%0d got=%h/%h exp=%h/%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]); else n_pass++;
    end
  endtask

  task automatic test_multi();
    bit ok1, ok2, okd;
    clear_logs();
    start_run(2'd3, 3'd2, 8'hFF, 8'h00);
    wait_feed(ok1);
    feed_poly(3, 8'h00, 1'b0, 64'h0);
    wait_feed(ok2);
    feed_poly(3, 8'h10, 1'b0, 64'h0);
    wait_done(okd);
    tick();
    n_total++; if (!(ok1 && ok2 && okd)) $display("FAIL multi_progress got=%b%b%b exp=111", ok1, ok2, okd); else n_pass++;
    n_total++; if (got_nonce.size() != 2) $display("FAIL multi_req_count got=%0d exp=2", got_nonce.size()); else n_pass++;
    if (got_nonce.size() == 2) begin
      n_total++; if (got_nonce[0] !== 8'hFF || got_nonce[1] !== 8'h00) $display("FAIL multi_nonces got=%h,%h exp=ff,00", got_nonce[0], got_nonce[1]); else n_pass++;
    end
    n_total++; if (got_addr.size() != 32) $display("FAIL multi_wr_count got=%0d exp=32", got_addr.size()); else n_pass++;
    for (int k = 0; k < 32 && k < got_addr.size(); k++) begin
      n_total++; if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k])
        $display("FAIL multi_wr%0d got=%h/%h exp=%h/%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]); else n_pass++;
    end
    n_total++; if (o_err !== 1'b0) $display("FAIL multi_err got=%b exp=0", o_err); else n_pass++;
  endtask

  task automatic test_fixed_patterns();
    logic [63:0] pat [2];
    logic [11:0] fld [2];
    bit ok;
    pat[0] = 64'hFFFF_FFFF_FFFF_FFFF; fld[0] = 12'd0;
    pat[1] = 64'hCCCC_CCCC_CCCC_CCCC; fld[1] = 12'd3327;
    for (int p = 0; p < 2; p++) begin
      clear_logs();
      start_run(2'd2, 3'd1, 8'h00, 8'h20);
      wait_feed(ok);
      feed_poly(2, 8'h20, 1'b1, pat[p]);
      wait_done(ok);
      tick();
      n_total++; if (got_addr.size() != 16) $display("FAIL fixed%0d_count got=%0d exp=16", p, got_addr.size()); else n_pass++;
      if (got_addr.size() == 16) begin
        n_total++; if (got_data[0][191:180] !== fld[p] || got_data[15][11:0] !== fld[p])
          $display("FAIL fixed%0d_field got=%0d/%0d exp=%0d", p, got_data[0][191:180], got_data[15][11:0], fld[p]); else n_pass++;
        for (int k = 0; k < 16; k++) begin
          n_total++; if (got_data[k] !== exp_data[k]) $display("FAIL fixed%0d_wr%0d got=%h exp=%h", p, k, got_data[k], exp_data[k]); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_handshake();
    logic [5:0] pv  = 6'b101101;
    logic [5:0] rdy = 6'b110001;
    bit ok;
    clear_logs();
    start_run(2'd2, 3'd1, 8'h11, 8'h30);
    wait_feed(ok);
    for (int k = 0; k < 6; k++) begin
      bus.i_prf_valid = pv[k]; bus.i_cbd_ibytes_ready = rdy[k];
      bus.i_prf_data = 64'h0123_4567_89AB_CDEF ^ 64'(k);
      #1;
      n_total++; if (bus.o_cbd_ibytes_valid !== pv[k] || bus.o_prf_ready !== rdy[k])
        $display("FAIL hs_gate%0d got=%b/%b exp=%b/%b", k, bus.o_cbd_ibytes_valid, bus.o_prf_ready, pv[k], rdy[k]); else n_pass++;
      n_total++; if (bus.o_cbd_ibytes !== (64'h0123_4567_89AB_CDEF ^ 64'(k))) $display("FAIL hs_bytes%0d got=%h", k, bus.o_cbd_ibytes); else n_pass++;
      tick();
    end
    bus.i_cbd_ibytes_ready = 1'b1;
    feed_poly(2, 8'h30, 1'b0, 64'h0);
    wait_done(ok);
    tick();
    n_total++; if (got_addr.size() != 16) $display("FAIL hs_count got=%0d exp=16", got_addr.size()); else n_pass++;
    for (int k = 0; k < 16 && k < got_addr.size(); k++) begin
      n_total++; if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k])
        $display("FAIL hs_wr%0d got=%h/%h exp=%h/%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]); else n_pass++;
    end
    bus.i_prf_valid = 1'b1;
    #1;
    n_total++; if (bus.o_cbd_ibytes_valid !== 1'b0 || bus.o_prf_ready !== 1'b0)
      $display("FAIL hs_idle_gate got=%b/%b exp=0/0", bus.o_cbd_ibytes_valid, bus.o_prf_ready); else n_pass++;
    bus.i_prf_valid = 1'b0;
  endtask

  task automatic test_zero_and_bad_eta();
    clear_logs();
    start_run(2'd2, 3'd0, 8'h33, 8'h44);
    n_total++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_err !== 1'b0) $display("FAIL zero_done got=%b%b%b exp=100", o_done, o_busy, o_err); else n_pass++;
    tick();
    n_total++; if (o_done !== 1'b0) $display("FAIL zero_pulse got=%b exp=0", o_done); else n_pass++;
    start_run(2'd1, 3'd1, 8'h33, 8'h44);
    n_total++; if (o_done !== 1'b1 || o_err !== 1'b1) $display("FAIL badeta_done got=%b/%b exp=1/1", o_done, o_err); else n_pass++;
    tick();
    n_total++; if (o_err !== 1'b1) $display("FAIL badeta_sticky got=%b exp=1", o_err); else n_pass++;
    n_total++; if (got_nonce.size() != 0 || got_addr.size() != 0) $display("FAIL zero_no_traffic got=%0d/%0d exp=0/0", got_nonce.size(), got_addr.size()); else n_pass++;
    start_run(2'd3, 3'd0, 8'h00, 8'h00);
    n_total++; if (o_err !== 1'b0) $display("FAIL err_clear got=%b exp=0", o_err); else n_pass++;
    tick();
  endtask

  task automatic test_errors();
    bit ok;
    clear_logs();
    start_run(2'd2, 3'd1, 8'h00, 8'h50);
    wait_feed(ok);
    bus.i_cbd_coeffs = 48'h924924924924; bus.i_cbd_coeffs_valid = 1'b1;
    tick();
    bus.i_cbd_coeffs_valid = 1'b0;
    n_total++; if (o_err !== 1'b1 || bus.o_mem_we !== 1'b1) $display("FAIL neg4_err got=%b/%b exp=1/1", o_err, bus.o_mem_we); else n_pass++;
    n_total++; if (bus.o_mem_wdata[191:180] !== 12'd3325 || bus.o_mem_wdata[11:0] !== 12'd3325)
      $display("FAIL neg4_value got=%0d/%0d exp=3325", bus.o_mem_wdata[191:180], bus.o_mem_wdata[11:0]); else n_pass++;
    bus.i_cbd_done = 1'b1; tick(); bus.i_cbd_done = 1'b0; tick();

    clear_logs();
    start_run(2'd2, 3'd1, 8'h00, 8'h60);
    wait_feed(ok);
    bus.i_cbd_coeffs = 48'd0; bus.i_cbd_coeffs_valid = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    n_total++; if (o_err !== 1'b0) $display("FAIL over_err_early got=%b exp=0", o_err); else n_pass++;
    tick();
    bus.i_cbd_coeffs_valid = 1'b0;
    n_total++; if (o_err !== 1'b1 || bus.o_mem_we !== 1'b0) $display("FAIL over_err got=%b/%b exp=1/0", o_err, bus.o_mem_we); else n_pass++;
    bus.i_cbd_done = 1'b1; tick(); bus.i_cbd_done = 1'b0;
    wait_done(ok); tick();
    n_total++; if (got_addr.size() != 16) $display("FAIL over_count got=%0d exp=16", got_addr.size()); else n_pass++;

    start_run(2'd2, 3'd1, 8'h00, 8'h70);
    wait_feed(ok);
    bus.i_cbd_done = 1'b1; tick(); bus.i_cbd_done = 1'b0;
    n_total++; if (o_err !== 1'b1 || o_done !== 1'b1) $display("FAIL under_err got=%b/%b exp=1/1", o_err, o_done); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    start_run(2'd2, 3'd2, 8'h20, 8'h40);
    wait_feed(ok);
    bus.i_cbd_coeffs = 48'h249249249249; bus.i_cbd_coeffs_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    bus.i_cbd_coeffs_valid = 1'b0;
    bus.i_prf_valid = 1'b1; bus.i_cbd_ibytes_ready = 1'b1;
    tick();
    n_total++; if (got_addr.size() != 5) $display("FAIL mid_writes got=%0d exp=5", got_addr.size()); else n_pass++;
    #2 i_rstn = 1'b0;
    #1;
    n_total++; if ({o_busy, o_done, o_err, bus.o_mem_we, bus.o_prf_ready, bus.o_cbd_ibytes_valid, bus.o_prf_req} !== 7'd0)
      $display("FAIL mid_reset_strobes got=%b exp=0", {o_busy, o_done, o_err, bus.o_mem_we, bus.o_prf_ready, bus.o_cbd_ibytes_valid, bus.o_prf_req}); else n_pass++;
    n_total++; if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_cbd_eta} !== '0)
      $display("FAIL mid_reset_fields got=%h/%h exp=0", bus.o_mem_addr, bus.o_mem_wdata); else n_pass++;
    bus.i_prf_valid = 1'b0;
    tick();
    i_rstn = 1'b1;
    tick();

    clear_logs();
    start_run(2'd2, 3'd1, 8'h07, 8'h80);
    wait_feed(ok);
    i_eta = 2'd3; i_num_poly = 3'd4; i_nonce_base = 8'h99; i_base_addr = 8'h00;
    i_start = 1'b1; tick(); i_start = 1'b0;
    n_total++; if (o_busy !== 1'b1 || bus.o_cbd_eta !== 2'd2) $display("FAIL busy_start got=%b/%0d exp=1/2", o_busy, bus.o_cbd_eta); else n_pass++;
    feed_poly(2, 8'h80, 1'b0, 64'h0);
    wait_done(ok);
    tick();
    n_total++; if (got_nonce.size() != 1 || n_done != 1) $display("FAIL restart_counts got=%0d/%0d exp=1/1", got_nonce.size(), n_done); else n_pass++;
    if (got_nonce.size() == 1) begin
      n_total++; if (got_nonce[0] !== 8'h07) $display("FAIL restart_nonce got=%h exp=07", got_nonce[0]); else n_pass++;
    end
    n_total++; if (got_addr.size() != 16 || o_err !== 1'b0) $display("FAIL restart_wr got=%0d/%b exp=16/0", got_addr.size(), o_err); else n_pass++;
    for (int k = 0; k < 16 && k < got_addr.size(); k++) begin
      n_total++; if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k])
        $display("FAIL restart_wr%0d got=%h/%h exp=%h/%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]); else n_pass++;
    end
  endtask

  initial begin
    bus.i_prf_data = '0; bus.i_prf_valid = 1'b0; bus.i_cbd_ibytes_ready = 1'b0;
    bus.i_cbd_coeffs = '0; bus.i_cbd_coeffs_valid = 1'b0; bus.i_cbd_done = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_fixed_patterns();
    test_handshake();
    test_zero_and_bad_eta();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
